// File: rtl/fdtd_readback.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : fdtd_readback
// Description : Host-side readback engine for the PE voltage memories.
//               When FDTD computing is off, a start pulse sweeps every PE
//               (major) and every z address (minor), issues one read per cycle
//               on the shared target_pe/addr bus, captures the selected PE's
//               read data one cycle later and streams (pe, addr, value) words
//               to the host through a small show-ahead FIFO (valid/ready).
// Ports       : clk, rst (async, active-low)
//               start, computing_on        - control inputs
//               pe_q                       - read data from the PE array
//               target_pe, addr, we        - read bus to the PE array
//               out_valid/out_ready, out_data/out_pe/out_addr - host stream
//               busy, done, abort_err      - status
// Revision    : 1.0 - initial release
// ============================================================================
module fdtd_readback #(
  parameter int Z_SIZE     = 110,
  parameter int R_SIZE     = 20,
  parameter int DW         = 27,
  parameter int AW         = 7,
  parameter int FIFO_DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          computing_on,
  input  logic [DW-1:0] pe_q,
  output logic [5:0]    target_pe,
  output logic [AW-1:0] addr,
  output logic          we,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic [5:0]    out_pe,
  output logic [AW-1:0] out_addr,
  output logic          busy,
  output logic          done,
  output logic          abort_err
);

  localparam int c_PW = $clog2(FIFO_DEPTH);
  localparam int c_CW = c_PW + 1;

  localparam logic [1:0] c_IDLE  = 2'd0;
  localparam logic [1:0] c_SWEEP = 2'd1;
  localparam logic [1:0] c_DRAIN = 2'd2;

  localparam logic [AW-1:0]   c_Z_LAST  = AW'(Z_SIZE - 1);
  localparam logic [5:0]      c_PE_LAST = 6'(R_SIZE - 1);
  localparam logic [c_CW-1:0] c_DEPTH   = c_CW'(FIFO_DEPTH);

  logic [1:0]      r_state;
  logic [5:0]      r_pe_cnt;
  logic [AW-1:0]   r_z_cnt;
  logic [5:0]      r_target_pe;
  logic [AW-1:0]   r_addr;
  logic            r_tag_v;
  logic [5:0]      r_tag_pe;
  logic [AW-1:0]   r_tag_addr;
  logic            r_abort_err;
  logic [c_PW-1:0] r_wptr;
  logic [c_PW-1:0] r_rptr;
  logic [c_CW-1:0] r_count;
  logic [DW-1:0]   r_mem_data [FIFO_DEPTH];
  logic [5:0]      r_mem_pe   [FIFO_DEPTH];
  logic [AW-1:0]   r_mem_addr [FIFO_DEPTH];

  logic w_busy;
  logic w_abort;
  logic w_credit;
  logic w_issue;
  logic w_push;
  logic w_pop;
  logic w_final;

  assign w_busy  = (r_state != c_IDLE);
  assign w_abort = w_busy && computing_on;
  // A read is only issued if its data is guaranteed a FIFO slot: stored words
  // plus the one possibly in flight must leave room.
  assign w_credit = (r_count + c_CW'(r_tag_v)) < c_DEPTH;
  assign w_issue  = (r_state == c_SWEEP) && w_credit && !computing_on;
  assign w_push   = r_tag_v;
  assign w_pop    = (r_count != '0) && out_ready;
  // Last word leaves the FIFO: nothing in flight and a single stored entry.
  assign w_final  = (r_state == c_DRAIN) && !r_tag_v &&
                    (r_count == c_CW'(1)) && out_ready && !computing_on;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= c_IDLE;
      r_pe_cnt    <= '0;
      r_z_cnt     <= '0;
      r_target_pe <= '0;
      r_addr      <= '0;
      r_tag_v     <= 1'b0;
      r_tag_pe    <= '0;
      r_tag_addr  <= '0;
      r_abort_err <= 1'b0;
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_count     <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        r_mem_data[i] <= '0;
        r_mem_pe[i]   <= '0;
        r_mem_addr[i] <= '0;
      end
    end else if (w_abort) begin
      // Abort discards everything queued or in flight; no done pulse.
      r_state     <= c_IDLE;
      r_tag_v     <= 1'b0;
      r_abort_err <= 1'b1;
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_count     <= '0;
    end else begin
      case (r_state)
        c_IDLE: begin
          if (start) begin
            if (computing_on) begin
              r_abort_err <= 1'b1;
            end else begin
              r_state     <= c_SWEEP;
              r_abort_err <= 1'b0;
              r_pe_cnt    <= '0;
              r_z_cnt     <= '0;
            end
          end
        end
        c_SWEEP: begin
          if (w_issue) begin
            r_target_pe <= r_pe_cnt;
            r_addr      <= r_z_cnt;
            if (r_z_cnt == c_Z_LAST) begin
              r_z_cnt <= '0;
              if (r_pe_cnt == c_PE_LAST) begin
                r_state <= c_DRAIN;
              end else begin
                r_pe_cnt <= r_pe_cnt + 6'd1;
              end
            end else begin
              r_z_cnt <= r_z_cnt + AW'(1);
            end
          end
        end
        c_DRAIN: begin
          if (w_final) begin
            r_state <= c_IDLE;
          end
        end
        default: r_state <= c_IDLE;
      endcase

      // One-stage tag pipe aligned with the fixed read latency of the array.
      r_tag_v <= w_issue;
      if (w_issue) begin
        r_tag_pe   <= r_pe_cnt;
        r_tag_addr <= r_z_cnt;
      end

      if (w_push) begin
        r_mem_data[r_wptr] <= pe_q;
        r_mem_pe[r_wptr]   <= r_tag_pe;
        r_mem_addr[r_wptr] <= r_tag_addr;
        r_wptr             <= r_wptr + c_PW'(1);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + c_PW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + c_CW'(1);
        2'b01:   r_count <= r_count - c_CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign target_pe = r_target_pe;
  assign addr      = r_addr;
  assign we        = 1'b0;
  assign out_valid = (r_count != '0);
  assign out_data  = r_mem_data[r_rptr];
  assign out_pe    = r_mem_pe[r_rptr];
  assign out_addr  = r_mem_addr[r_rptr];
  assign busy      = w_busy;
  assign done      = w_final;
  assign abort_err = r_abort_err;

endmodule
`default_nettype wire

// File: tb/tb_fdtd_readback.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_fdtd_readback
// Description : Self-checking bench for fdtd_readback. The PE array is
//               modelled as returning pe*256+addr for the selected PE; each
//               accepted start pushes the full expected word order onto a
//               queue which the output monitor pops on every transfer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fdtd_readback;

  localparam int Z_SIZE     = 110;
  localparam int R_SIZE     = 20;
  localparam int DW         = 27;
  localparam int AW         = 7;
  localparam int FIFO_DEPTH = 4;
  localparam int N_WORDS    = Z_SIZE * R_SIZE;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic          computing_on = 1'b0;
  logic          out_ready = 1'b0;
  logic [DW-1:0] pe_q;
  logic [5:0]    target_pe;
  logic [AW-1:0] addr;
  logic          we;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic [5:0]    out_pe;
  logic [AW-1:0] out_addr;
  logic          busy;
  logic          done;
  logic          abort_err;

  fdtd_readback #(
    .Z_SIZE(Z_SIZE), .R_SIZE(R_SIZE), .DW(DW), .AW(AW), .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .computing_on(computing_on),
    .pe_q(pe_q), .target_pe(target_pe), .addr(addr), .we(we),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_pe(out_pe), .out_addr(out_addr), .busy(busy), .done(done),
    .abort_err(abort_err)
  );

  always #5 clk = ~clk;

  // PE array model: the selected memory returns pe*256+addr.
  assign pe_q = DW'({target_pe, 8'h00}) + DW'(addr);

  typedef struct packed {
    logic [5:0]    pe;
    logic [AW-1:0] a;
  } tag_t;

  typedef struct {
    int            cyc;
    logic [5:0]    tpe;
    logic [AW-1:0] ta;
    logic          v;
    logic [5:0]    ope;
    logic [AW-1:0] oa;
  } vec_t;

  tag_t q[$];
  tag_t mon_e;
  vec_t tbl[8];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   n_words  = 0;
  int   ready_mode = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Host ready pattern: 0 = stalled, 1 = always ready, 2 = random 30% duty.
  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0:       out_ready = 1'b0;
      1:       out_ready = 1'b1;
      default: out_ready = ($urandom_range(0, 9) < 3);
    endcase
  end

  // Output monitor / scoreboard.
  always @(negedge clk) begin
    if (rst) begin
      if (out_valid && out_ready) begin
        n_words++;
        if (q.size() == 0) begin
          chk("extra_word", 1, 0);
        end else begin
          mon_e = q.pop_front();
          chk("word_pe", out_pe, mon_e.pe);
          chk("word_addr", out_addr, mon_e.a);
          chk("word_data", out_data, 64'(mon_e.pe) * 256 + 64'(mon_e.a));
          chk("done_on_xfer", done, (q.size() == 0));
        end
      end else if (done) begin
        chk("done_no_xfer", done, 0);
      end
    end
  end

  task automatic push_sweep();
    q.delete();
    for (int p = 0; p < R_SIZE; p++)
      for (int z = 0; z < Z_SIZE; z++)
        q.push_back('{pe: 6'(p), a: AW'(z)});
  endtask

  // Drives a one-cycle start pulse; returns 1 ns into the cycle after it.
  task automatic do_start(input bit expect_accept);
    @(posedge clk); #1;
    start = 1'b1;
    if (expect_accept) push_sweep();
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_idle(input int max_cyc, output int busy_cnt,
                           output int done_cnt, output int first_valid);
    busy_cnt = 0; done_cnt = 0; first_valid = -1;
    for (int c = 1; c <= max_cyc; c++) begin
      @(negedge clk);
      if (busy) busy_cnt++;
      if (done) done_cnt++;
      if (out_valid && first_valid < 0) first_valid = c;
      if (!busy) break;
    end
    chk("sweep_timeout", busy, 0);
  endtask

  task automatic wait_word(input int pe, input int a, input string name);
    bit found = 1'b0;
    for (int c = 0; c < 5000; c++) begin
      @(negedge clk);
      if (out_valid && out_pe == 6'(pe) && out_addr == AW'(a)) begin
        found = 1'b1;
        break;
      end
    end
    chk(name, found, 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int bc, dc, fv;

    // Stalled host after start: cycle, target(pe,addr), valid, head(pe,addr).
    tbl[0] = '{1, 0, 0, 0, 0, 0};
    tbl[1] = '{2, 0, 0, 0, 0, 0};
    tbl[2] = '{3, 0, 1, 1, 0, 0};
    tbl[3] = '{4, 0, 2, 1, 0, 0};
    tbl[4] = '{5, 0, 3, 1, 0, 0};
    tbl[5] = '{6, 0, 3, 1, 0, 0};
    tbl[6] = '{7, 0, 3, 1, 0, 0};
    tbl[7] = '{8, 0, 3, 1, 0, 0};

    // Reset state.
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_target_pe", target_pe, 0);
    chk("rst_addr", addr, 0);
    chk("rst_we", we, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_abort_err", abort_err, 0);
    chk("rst_out_data", out_data, 0);
    @(posedge clk); #1;
    rst = 1'b1;

    // Host stalled: exactly FIFO_DEPTH reads, then frozen.
    ready_mode = 0;
    do_start(1);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk($sformatf("stall_tpe_c%0d", tbl[i].cyc), target_pe, tbl[i].tpe);
      chk($sformatf("stall_addr_c%0d", tbl[i].cyc), addr, tbl[i].ta);
      chk($sformatf("stall_valid_c%0d", tbl[i].cyc), out_valid, tbl[i].v);
      if (tbl[i].v) begin
        chk($sformatf("stall_ope_c%0d", tbl[i].cyc), out_pe, tbl[i].ope);
        chk($sformatf("stall_oaddr_c%0d", tbl[i].cyc), out_addr, tbl[i].oa);
      end
    end
    ready_mode = 1;
    n_words = 0;
    do_start(0);  // start while busy must be ignored
    wait_idle(5000, bc, dc, fv);
    chk("stall_words", n_words, N_WORDS);
    chk("stall_done_cnt", dc, 1);
    chk("stall_q_empty", q.size(), 0);

    // Full-rate sweep: latency, busy length, done.
    n_words = 0;
    do_start(1);
    wait_idle(5000, bc, dc, fv);
    chk("full_first_valid_cycle", fv, 3);
    chk("full_busy_cycles", bc, N_WORDS + 2);
    chk("full_done_cnt", dc, 1);
    chk("full_words", n_words, N_WORDS);
    chk("full_q_empty", q.size(), 0);
    chk("full_abort_err", abort_err, 0);

    // Random backpressure.
    ready_mode = 2;
    n_words = 0;
    do_start(1);
    wait_idle(30000, bc, dc, fv);
    chk("rand_words", n_words, N_WORDS);
    chk("rand_done_cnt", dc, 1);
    chk("rand_q_empty", q.size(), 0);

    // computing_on rises mid-sweep at word (7,50).
    ready_mode = 1;
    do_start(1);
    wait_word(7, 50, "abort_word_seen");
    computing_on = 1'b1;
    @(posedge clk); #1;
    q.delete();
    @(negedge clk);
    chk("abort_out_valid", out_valid, 0);
    chk("abort_busy", busy, 0);
    chk("abort_err_set", abort_err, 1);
    chk("abort_no_done", done, 0);
    @(posedge clk); #1;
    computing_on = 1'b0;
    n_words = 0;
    do_start(1);
    @(negedge clk);
    chk("restart_abort_err_clr", abort_err, 0);
    wait_idle(5000, bc, dc, fv);
    chk("restart_words", n_words, N_WORDS);
    chk("restart_done_cnt", dc, 1);

    // start refused while computing_on.
    @(posedge clk); #1;
    computing_on = 1'b1;
    do_start(0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("refuse_busy", busy, 0);
      chk("refuse_valid", out_valid, 0);
      chk("refuse_tpe", target_pe, R_SIZE - 1);
      chk("refuse_addr", addr, Z_SIZE - 1);
      chk("refuse_abort_err", abort_err, 1);
    end
    @(posedge clk); #1;
    computing_on = 1'b0;

    // Asynchronous reset mid-sweep at word (3,10).
    do_start(1);
    wait_word(3, 10, "reset_word_seen");
    rst = 1'b0;
    #1;
    chk("arst_target_pe", target_pe, 0);
    chk("arst_addr", addr, 0);
    chk("arst_out_valid", out_valid, 0);
    chk("arst_busy", busy, 0);
    chk("arst_out_pe", out_pe, 0);
    chk("arst_out_addr", out_addr, 0);
    chk("arst_out_data", out_data, 0);
    chk("arst_abort_err", abort_err, 0);
    q.delete();
    @(posedge clk); #1;
    rst = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("post_rst_valid", out_valid, 0);
      chk("post_rst_busy", busy, 0);
    end
    n_words = 0;
    do_start(1);
    wait_idle(5000, bc, dc, fv);
    chk("post_rst_words", n_words, N_WORDS);
    chk("post_rst_done_cnt", dc, 1);
    chk("post_rst_q_empty", q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
